amo_sequencer: RTL

Multi-cycle controller that executes RV32A atomic instructions flagged by the decoder (`atomic_op`, `mem_read` and `mem_write` all set). It turns one atomic into a sequenced read / modify / write on the single data-memory port and holds the pipeline while it runs. It also owns the LR/SC reservation. It sits between execute and the data-memory interface, in parallel with the normal load/store path.

---
 rtl/amo_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/amo_sequencer.sv
// RV32A atomic sequencer: read/modify/write on the data port, LR/SC reservation.
// Define AMO_MINMAX_EN to build AMOMIN/AMOMAX/AMOMINU/AMOMAXU support.
module amo_sequencer #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [4:0]            atomic_op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           rs2_value,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_read_req,
  output logic                  mem_write_req,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  input  logic                  snoop_valid,
  input  logic [ADDR_WIDTH-1:0] snoop_addr,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           result,
  output logic                  fault
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SWAP = 5'b00001;
  localparam logic [4:0] OP_LR   = 5'b00010;
  localparam logic [4:0] OP_SC   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01100;
`ifdef AMO_MINMAX_EN
  localparam logic [4:0] OP_MIN  = 5'b10000;
  localparam logic [4:0] OP_MAX  = 5'b10100;
  localparam logic [4:0] OP_MINU = 5'b11000;
  localparam logic [4:0] OP_MAXU = 5'b11100;
`endif

  state_e                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_rs2, r_old, r_result, w_new;
  logic [4:0]            r_op;
  logic                  r_fault;
  logic                  r_resv_valid;
  logic [ADDR_WIDTH-3:0] r_resv_addr;
  logic                  w_op_ok, w_is_lr, w_is_sc, w_misaligned, w_snoop_hit, w_sc_ok;
  logic                  w_unused_snoop_lsb;

  assign w_is_lr            = (atomic_op == OP_LR);
  assign w_is_sc            = (atomic_op == OP_SC);
  assign w_misaligned       = (addr[1:0] != 2'b00);
  assign w_snoop_hit        = snoop_valid && r_resv_valid &&
                              (snoop_addr[ADDR_WIDTH-1:2] == r_resv_addr);
  // A snoop landing in the same cycle as the SC check defeats the SC.
  assign w_sc_ok            = r_resv_valid && (r_resv_addr == addr[ADDR_WIDTH-1:2]) && !w_snoop_hit;
  assign w_unused_snoop_lsb = ^snoop_addr[1:0];

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign fault  = done && r_fault;

  always_comb begin
    w_op_ok = 1'b0;
    case (atomic_op)
      OP_ADD, OP_SWAP, OP_XOR, OP_OR, OP_AND: w_op_ok = 1'b1;
`ifdef AMO_MINMAX_EN
      OP_MIN, OP_MAX, OP_MINU, OP_MAXU:       w_op_ok = 1'b1;
`endif
      default:                                w_op_ok = 1'b0;
    endcase
  end

  // SC and SWAP both store rs2 unchanged, so they share the default arm.
  always_comb begin
    w_new = r_rs2;
    case (r_op)
      OP_ADD:  w_new = r_old + r_rs2;
      OP_XOR:  w_new = r_old ^ r_rs2;
      OP_OR:   w_new = r_old | r_rs2;
      OP_AND:  w_new = r_old & r_rs2;
`ifdef AMO_MINMAX_EN
      OP_MIN:  w_new = ($signed(r_old) < $signed(r_rs2)) ? r_old : r_rs2;
      OP_MAX:  w_new = ($signed(r_old) > $signed(r_rs2)) ? r_old : r_rs2;
      OP_MINU: w_new = (r_old < r_rs2) ? r_old : r_rs2;
      OP_MAXU: w_new = (r_old > r_rs2) ? r_old : r_rs2;
`endif
      default: w_new = r_rs2;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_misaligned)          w_next = S_DONE;
          else if (w_is_lr || w_op_ok) w_next = S_READ;
          else if (w_is_sc)          w_next = w_sc_ok ? S_WRITE : S_DONE;
          else                       w_next = S_DONE;
        end
      end
      S_READ: begin
        mem_read_req = 1'b1;
        mem_addr     = r_addr;
        if (mem_ready) w_next = (r_op == OP_LR) ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        mem_write_req = 1'b1;
        mem_addr      = r_addr;
        mem_wdata     = w_new;
        if (mem_ready) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Later assignments win: an LR completing overrides a same-cycle snoop clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_addr       <= '0;
      r_rs2        <= '0;
      r_old        <= '0;
      r_op         <= '0;
      r_result     <= '0;
      r_fault      <= 1'b0;
      r_resv_valid <= 1'b0;
      r_resv_addr  <= '0;
    end else begin
      if (w_snoop_hit) r_resv_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr  <= addr;
            r_rs2   <= rs2_value;
            r_op    <= atomic_op;
            r_fault <= 1'b0;
            if (w_is_sc) r_resv_valid <= 1'b0;
            if (w_misaligned || !(w_is_lr || w_is_sc || w_op_ok)) begin
              r_fault  <= 1'b1;
              r_result <= '0;
            end else if (w_is_sc && !w_sc_ok) begin
              r_result <= 32'd1;
            end
          end
        end
        S_READ: begin
          if (mem_ready) begin
            r_old <= mem_rdata;
            if (r_op == OP_LR) begin
              r_result     <= mem_rdata;
              r_resv_valid <= 1'b1;
              r_resv_addr  <= r_addr[ADDR_WIDTH-1:2];
            end
          end
        end
        S_WRITE: begin
          if (mem_ready) r_result <= (r_op == OP_SC) ? 32'd0 : r_old;
        end
        default: ;
      endcase
    end
  end

endmodule
